// File: rtl/load_store_unit.sv
// RV32I memory-access stage: drives a valid/ready word-addressed memory port with byte lanes
// and stalls the core until each access completes. Optional macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [2:0]       Funct3,
  output logic [WIDTH-1:0] ReadData,
  output logic             Stall,
  output logic             MisalignErr,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_rsp_valid,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_addr, r_wdata, r_rdata;
  logic [3:0]       r_be;
  logic             r_we;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;

  logic             w_start, w_is_b, w_is_h, w_trap;
  logic [1:0]       w_off;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata, w_load_ext;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;

  assign w_start = MemRead | MemWrite;
  assign w_is_b  = (Funct3 == 3'b000) | (Funct3 == 3'b100);
  assign w_is_h  = (Funct3 == 3'b001) | (Funct3 == 3'b101);
  assign w_off   = ALUResult[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_mis;
  assign w_trap = (w_is_h & w_off[0]) | (~w_is_b & ~w_is_h & (w_off != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  // Half/word lane selection only looks at the bits that survive force-alignment.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteData;
    if (w_is_b) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{WriteData[7:0]}};
    end else if (w_is_h) begin
      w_be    = 4'b0011 << {w_off[1], 1'b0};
      w_wdata = {2{WriteData[15:0]}};
    end
  end

  always_comb begin
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (r_off)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    case (r_f3)
      3'b000:  w_load_ext = {{(WIDTH-8){w_byte[7]}}, w_byte};
      3'b100:  w_load_ext = {{(WIDTH-8){1'b0}}, w_byte};
      3'b001:  w_load_ext = {{(WIDTH-16){w_half[15]}}, w_half};
      3'b101:  w_load_ext = {{(WIDTH-16){1'b0}}, w_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_start) w_state_next = w_trap ? StDone : StReq;
      StReq:   if (mem_req_ready) w_state_next = r_we ? StDone : StWait;
      StWait:  if (mem_rsp_valid) w_state_next = StDone;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_off   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_mis   <= 1'b0;
`endif
    end else begin
      if (r_state == StIdle && w_start) begin
        r_addr  <= {ALUResult[WIDTH-1:2], 2'b00};
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_we    <= MemWrite;
        r_f3    <= Funct3;
        r_off   <= w_off;
`ifdef LSU_MISALIGN_TRAP_EN
        r_mis   <= w_trap;
`endif
      end
      if (r_state == StWait && mem_rsp_valid) r_rdata <= w_load_ext;
    end
  end

  always_comb begin
    mem_req_valid = rst_n & (r_state == StReq);
    Stall         = rst_n & (((r_state == StIdle) & w_start) | (r_state == StReq) |
                             (r_state == StWait));
`ifdef LSU_MISALIGN_TRAP_EN
    MisalignErr   = (r_state == StDone) & r_mis;
`else
    MisalignErr   = 1'b0;
`endif
    mem_we        = r_we;
    mem_be        = r_be;
    mem_addr      = r_addr;
    mem_wdata     = r_wdata;
    ReadData      = r_rdata;
  end

endmodule
